// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
//
// Programmable rectangular waveform generator. Each pulse is HIGH for H cycles
// followed by LOW for L cycles. Three run modes:
//   mode 0 : free-running square wave, ends only on stop or rst
//   mode 1 : single pulse, then done
//   mode 2 : burst of N pulses, then done
//   mode 3 : reserved, behaves as single
// Configuration (mode, H, L, N) is captured on the edge that accepts start and
// is held for the whole run, so input changes while busy have no effect.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   launch request, sampled only in IDLE
//   stop       in   abort request, sampled only in HIGH or LOW
//   mode       in   [1:0] run mode (see above)
//   high_len   in   [CNT_W-1:0] high-phase cycles, 0 treated as 1
//   low_len    in   [CNT_W-1:0] low-phase cycles, 0 treated as 1
//   burst_len  in   [BURST_W-1:0] pulses in burst mode, 0 treated as 1
//   y          out  registered waveform, 1 only in HIGH
//   busy       out  registered, 1 in HIGH and LOW
//   done       out  registered one-cycle strobe on normal completion
// -----------------------------------------------------------------------------
module pulse_train_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   high_len,
    input  logic [CNT_W-1:0]   low_len,
    input  logic [BURST_W-1:0] burst_len,
    output logic               y,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [1:0] MODE_FREE  = 2'd0;
    localparam logic [1:0] MODE_BURST = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BURST_W-1:0] pcnt, pcnt_nxt;
    logic [1:0]         mode_q, mode_nxt;
    logic [CNT_W-1:0]   h_q, h_nxt;
    logic [CNT_W-1:0]   l_q, l_nxt;
    logic               done_nxt;

    // Effective durations/count with zero mapped to one.
    logic [CNT_W-1:0]   h_eff, l_eff;
    logic [BURST_W-1:0] n_eff;

    assign h_eff = (high_len  == '0) ? CNT_W'(1)   : high_len;
    assign l_eff = (low_len   == '0) ? CNT_W'(1)   : low_len;
    assign n_eff = (burst_len == '0) ? BURST_W'(1) : burst_len;

    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold its value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pcnt_nxt  = pcnt;
        mode_nxt  = mode_q;
        h_nxt     = h_q;
        l_nxt     = l_q;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                // start wins over stop here; stop is meaningless in IDLE.
                if (start) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = h_eff - CNT_W'(1);
                    mode_nxt  = mode;
                    h_nxt     = h_eff;
                    l_nxt     = l_eff;
                    // Single/reserved run exactly one pulse; free-run ignores pcnt.
                    pcnt_nxt  = (mode == MODE_BURST) ? n_eff - BURST_W'(1) : '0;
                end
            end

            S_HIGH: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = l_q - CNT_W'(1);
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end

            S_LOW: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    if (mode_q == MODE_FREE) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = h_q - CNT_W'(1);
                    end else if (pcnt != '0) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = h_q - CNT_W'(1);
                        pcnt_nxt  = pcnt - BURST_W'(1);
                    end else begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments make every register update from the
    // pre-edge values, so the order of statements in this block is irrelevant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            pcnt   <= '0;
            mode_q <= '0;
            h_q    <= '0;
            l_q    <= '0;
            y      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            pcnt   <= pcnt_nxt;
            mode_q <= mode_nxt;
            h_q    <= h_nxt;
            l_q    <= l_nxt;
            // Outputs are decoded from the next state so they line up with it.
            y      <= (state_nxt == S_HIGH);
            busy   <= (state_nxt != S_IDLE);
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
//
// Self-checking bench for pulse_train_gen. The stimulus process drives inputs
// and pushes expected {y,busy,done} values, tagged with the cycle in which
// they are due, into a scoreboard queue. A monitor on the falling edge pops
// and compares entries as their cycle comes up.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;

    localparam int CNT_W   = 8;
    localparam int BURST_W = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   high_len;
    logic [CNT_W-1:0]   low_len;
    logic [BURST_W-1:0] burst_len;
    logic               y;
    logic               busy;
    logic               done;

    pulse_train_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .high_len  (high_len),
        .low_len   (low_len),
        .burst_len (burst_len),
        .y         (y),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: during the period after rising edge e, cyc == e.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [2:0] v;     // {y, busy, done}
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cyc %0d: {y,busy,done} got %b want %b", name, cyc, act, req);
        end
    endtask

    task automatic push(input int at, input logic [2:0] v, input string name);
        exp_t e;
        e.at   = at;
        e.v    = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Expected waveform of a run accepted at edge c+1: n pulses of h high and
    // l low cycles, optionally followed by the done cycle.
    task automatic push_train(input int c, input int h, input int l, input int n,
                              input bit with_done, input string name);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < h + l; i++)
                push(c + 1 + p * (h + l) + i, {(i < h), 1'b1, 1'b0}, name);
        if (with_done)
            push(c + n * (h + l) + 1, 3'b001, name);
    endtask

    // Monitor: compares whatever is due this cycle; stale entries are misses.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: entry for cyc %0d never compared (now %0d)", e.name, e.at, cyc);
            end else begin
                check(e.name, {y, busy, done}, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic launch(input logic [1:0] m, input int h, input int l, input int n);
        mode      = m;
        high_len  = CNT_W'(h);
        low_len   = CNT_W'(l);
        burst_len = BURST_W'(n);
        start     = 1'b1;
    endtask

    initial begin
        int         c;
        logic [5:0] pat;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 2'd0; high_len = '0; low_len = '0; burst_len = '0;
        repeat (2) tick();
        push(cyc, 3'b000, "reset");
        rst = 1'b0;

        // Single pulse H=3 L=2: y 1..3, low 4..5, done at 6, idle at 7.
        c = cyc;
        launch(2'd1, 3, 2, 0);
        push_train(c, 3, 2, 1, 1'b1, "single_h3_l2");
        push(c + 7, 3'b000, "single_idle");
        tick(); start = 1'b0;
        wait_to(c + 8);

        // Burst N=3 H=1 L=1: y 101010, done at 7.
        c = cyc;
        launch(2'd2, 1, 1, 3);
        pat = 6'b101010;
        for (int i = 0; i < 6; i++) push(c + 1 + i, {pat[5 - i], 1'b1, 1'b0}, "burst3");
        push(c + 7, 3'b001, "burst3_done");
        tick(); start = 1'b0;
        wait_to(c + 8);

        // burst_len=0 behaves as one pulse.
        c = cyc;
        launch(2'd2, 1, 1, 0);
        push(c + 1, 3'b110, "burst0");
        push(c + 2, 3'b010, "burst0");
        push(c + 3, 3'b001, "burst0_done");
        push(c + 4, 3'b000, "burst0_idle");
        tick(); start = 1'b0;
        wait_to(c + 5);

        // Free-run H=2 L=2, stop in cycle 5; no done ever.
        c = cyc;
        launch(2'd0, 2, 2, 0);
        push(c + 1, 3'b110, "free");
        push(c + 2, 3'b110, "free");
        push(c + 3, 3'b010, "free");
        push(c + 4, 3'b010, "free");
        push(c + 5, 3'b110, "free");
        for (int i = 6; i <= 10; i++) push(c + i, 3'b000, "free_stopped");
        tick(); start = 1'b0;
        wait_to(c + 5);
        stop = 1'b1;
        tick(); stop = 1'b0;
        wait_to(c + 11);

        // Zero lengths in single mode: one high, one low, done.
        c = cyc;
        launch(2'd1, 0, 0, 0);
        push(c + 1, 3'b110, "zero_len");
        push(c + 2, 3'b010, "zero_len");
        push(c + 3, 3'b001, "zero_len_done");
        push(c + 4, 3'b000, "zero_len_idle");
        tick(); start = 1'b0;
        wait_to(c + 5);

        // Inputs disturbed mid-run (start pulse, high_len, mode) are ignored.
        c = cyc;
        launch(2'd1, 4, 2, 0);
        push_train(c, 4, 2, 1, 1'b1, "ignore_inputs");
        push(c + 8, 3'b000, "ignore_no_queue");
        tick(); start = 1'b0;
        wait_to(c + 2);
        start = 1'b1; high_len = 8'd1; mode = 2'd0;
        tick(); start = 1'b0; mode = 2'd1;
        wait_to(c + 9);

        // start held through done: second run starts the cycle after done.
        c = cyc;
        launch(2'd1, 1, 1, 0);
        push_train(c, 1, 1, 1, 1'b1, "b2b_first");
        push_train(c + 3, 1, 1, 1, 1'b1, "b2b_second");
        push(c + 7, 3'b000, "b2b_idle");
        wait_to(c + 4);
        start = 1'b0;
        wait_to(c + 8);

        // Reset mid-burst N=4 H=2 L=2 in cycle 5, then a fresh full burst.
        c = cyc;
        launch(2'd2, 2, 2, 4);
        push(c + 1, 3'b110, "rst_burst");
        push(c + 2, 3'b110, "rst_burst");
        push(c + 3, 3'b010, "rst_burst");
        push(c + 4, 3'b010, "rst_burst");
        push(c + 5, 3'b110, "rst_burst");
        push(c + 6, 3'b000, "rst_burst_cleared");
        push(c + 7, 3'b000, "rst_burst_cleared");
        tick(); start = 1'b0;
        wait_to(c + 5);
        rst = 1'b1;
        tick(); rst = 1'b0;
        wait_to(c + 8);
        c = cyc;
        launch(2'd2, 2, 2, 4);
        push_train(c, 2, 2, 4, 1'b1, "fresh_burst4");
        tick(); start = 1'b0;
        wait_to(c + 18);

        // Maximum burst count: 15 pulses, H=1 L=1.
        c = cyc;
        launch(2'd2, 1, 1, 15);
        push_train(c, 1, 1, 15, 1'b1, "burst_max");
        tick(); start = 1'b0;
        wait_to(c + 32);

        // Maximum high length: 255 high cycles; reserved mode acts as single.
        c = cyc;
        launch(2'd3, 255, 1, 0);
        push_train(c, 255, 1, 1, 1'b1, "high_max");
        push(c + 258, 3'b000, "high_max_idle");
        tick(); start = 1'b0;
        wait_to(c + 259);

        // Bounded drain of anything still pending.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
